// File: rtl/commit_flush_ctrl.sv
// commit_flush_ctrl
//   Commit-stage flush and redirect controller. It accepts one write-back flush
//   request while in RUN and picks a single winner (excp > ertn > icacop > idle
//   > refetch). In the next cycle it pulses pipe_flush, latches the fetch target
//   and moves to a holding state. From there it hands a redirect to fetch once
//   the pending condition clears (cache maintenance done, interrupt pending, or
//   immediately).
//
// Ports
//   clk, reset            : clock; synchronous active-high reset
//   *_flush               : one-cycle flush requests from write-back
//   excp_tlbrefill        : selects csr_tlbrentry instead of csr_eentry for excp
//   ws_pc                 : PC of the committing instruction
//   csr_eentry/tlbrentry/era : CSR-provided targets
//   int_pending           : wakes the controller from IDLE
//   icacop_done           : I-cache maintenance complete pulse
//   redirect_ready        : fetch accepts the redirect
//   pipe_flush            : one-cycle flush pulse to all stages
//   redirect_valid/pc     : fetch redirect handshake
//   fetch_hold            : blocks fetch in every state except RUN
//   ctrl_state            : RUN=0, REDIR=1, CACOP=2, IDLE=3
//   flush_cnt             : saturating count of accepted flushes
module commit_flush_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic        refetch_flush,
    input  logic        icacop_flush,
    input  logic        idle_flush,
    input  logic        excp_tlbrefill,
    input  logic [31:0] ws_pc,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic [31:0] csr_era,
    input  logic        int_pending,
    input  logic        icacop_done,
    input  logic        redirect_ready,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        fetch_hold,
    output logic [1:0]  ctrl_state,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_REDIR = 2'd1;
    localparam logic [1:0] S_CACOP = 2'd2;
    localparam logic [1:0] S_IDLE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic [15:0] cnt_q, cnt_d;
    // Remembers an icacop_done that arrived in the same cycle as the request,
    // so that it is not lost while the controller enters CACOP.
    logic        done_q, done_d;

    logic        any_req;
    logic [31:0] seq_pc;

    assign any_req = excp_flush | ertn_flush | icacop_flush | idle_flush | refetch_flush;
    assign seq_pc  = ws_pc + 32'd4;  // wraps modulo 2^32

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        cnt_d   = cnt_q;
        done_d  = done_q;
        case (state_q)
            S_RUN: begin
                if (any_req) begin
                    flush_d = 1'b1;
                    done_d  = 1'b0;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (excp_flush) begin
                        pc_d    = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
                        state_d = S_REDIR;
                    end else if (ertn_flush) begin
                        pc_d    = csr_era;
                        state_d = S_REDIR;
                    end else if (icacop_flush) begin
                        pc_d    = seq_pc;
                        state_d = S_CACOP;
                        done_d  = icacop_done;
                    end else if (idle_flush) begin
                        pc_d    = seq_pc;
                        state_d = S_IDLE;
                    end else begin
                        pc_d    = seq_pc;
                        state_d = S_REDIR;
                    end
                end
            end
            S_CACOP: begin
                if (done_q || icacop_done) begin
                    state_d = S_REDIR;
                    done_d  = 1'b0;
                end
            end
            S_IDLE: begin
                if (int_pending) begin
                    state_d = S_REDIR;
                end
            end
            default: begin  // S_REDIR: target held stable until fetch takes it
                if (redirect_ready) begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= 32'd0;
            flush_q <= 1'b0;
            cnt_q   <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign pipe_flush     = flush_q;
    assign redirect_valid = (state_q == S_REDIR);
    assign redirect_pc    = pc_q;
    assign fetch_hold     = (state_q != S_RUN);
    assign ctrl_state     = state_q;
    assign flush_cnt      = cnt_q;

endmodule

// File: tb/tb_commit_flush_ctrl.sv
module tb_commit_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush;
    logic        excp_tlbrefill;
    logic [31:0] ws_pc, csr_eentry, csr_tlbrentry, csr_era;
    logic        int_pending, icacop_done, redirect_ready;
    logic        pipe_flush, redirect_valid, fetch_hold;
    logic [31:0] redirect_pc;
    logic [1:0]  ctrl_state;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    commit_flush_ctrl dut (
        .clk(clk), .reset(reset),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
        .icacop_flush(icacop_flush), .idle_flush(idle_flush), .excp_tlbrefill(excp_tlbrefill),
        .ws_pc(ws_pc), .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry), .csr_era(csr_era),
        .int_pending(int_pending), .icacop_done(icacop_done), .redirect_ready(redirect_ready),
        .pipe_flush(pipe_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_hold(fetch_hold), .ctrl_state(ctrl_state), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        excp_flush = 0; ertn_flush = 0; refetch_flush = 0;
        icacop_flush = 0; idle_flush = 0; excp_tlbrefill = 0;
        icacop_done = 0; int_pending = 0;
    endtask

    task automatic do_reset();
        clr_req();
        redirect_ready = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        ws_pc = 32'h1C00_0000; csr_eentry = 0; csr_tlbrentry = 0; csr_era = 0;
        do_reset();
        checks++;
        if ({pipe_flush, redirect_valid, fetch_hold} !== 3'b000 || ctrl_state !== 2'd0 ||
            redirect_pc !== 32'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: pf=%b rv=%b fh=%b st=%0d pc=%h cnt=%0d, need all zero",
                     pipe_flush, redirect_valid, fetch_hold, ctrl_state, redirect_pc, flush_cnt);
        end
        tick();
        checks++;
        if (pipe_flush !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: pf=%b rv=%b, need 0 0", pipe_flush, redirect_valid);
        end
    endtask

    task automatic test_quiet();
        do_reset();
        ws_pc = 32'h1234_5678; csr_era = 32'h0000_1000; redirect_ready = 1;
        repeat (3) tick();
        checks++;
        if (pipe_flush !== 0 || redirect_valid !== 0 || fetch_hold !== 0 || ctrl_state !== 2'd0 ||
            redirect_pc !== 32'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL quiet_run: st=%0d pf=%b rv=%b fh=%b pc=%h cnt=%0d, need static zero",
                     ctrl_state, pipe_flush, redirect_valid, fetch_hold, redirect_pc, flush_cnt);
        end
        redirect_ready = 0;
    endtask

    task automatic test_tlbrefill();
        do_reset();
        excp_flush = 1; excp_tlbrefill = 1; csr_tlbrentry = 32'h1C00_8000;
        csr_eentry = 32'h1C00_4000; redirect_ready = 1;
        tick();
        clr_req();
        checks++;
        if (pipe_flush !== 1 || ctrl_state !== 2'd1 || redirect_valid !== 1 ||
            redirect_pc !== 32'h1C00_8000 || flush_cnt !== 16'd1 || fetch_hold !== 1) begin
            errors++;
            $display("FAIL tlbrefill_T1: pf=%b st=%0d rv=%b pc=%h cnt=%0d fh=%b, need 1 1 1 1c008000 1 1",
                     pipe_flush, ctrl_state, redirect_valid, redirect_pc, flush_cnt, fetch_hold);
        end
        tick();
        checks++;
        if (ctrl_state !== 2'd0 || pipe_flush !== 0 || redirect_valid !== 0 || fetch_hold !== 0) begin
            errors++;
            $display("FAIL tlbrefill_T2: st=%0d pf=%b rv=%b fh=%b, need RUN 0 0 0",
                     ctrl_state, pipe_flush, redirect_valid, fetch_hold);
        end
        redirect_ready = 0;
    endtask

    task automatic test_priority();
        do_reset();
        excp_flush = 1; ertn_flush = 1; csr_eentry = 32'h1C00_4000; csr_era = 32'h1C00_2000;
        tick();
        clr_req();
        checks++;
        if (redirect_pc !== 32'h1C00_4000 || flush_cnt !== 16'd1 || ctrl_state !== 2'd1) begin
            errors++;
            $display("FAIL prio_excp_ertn: pc=%h cnt=%0d st=%0d, need 1c004000 1 1",
                     redirect_pc, flush_cnt, ctrl_state);
        end
        redirect_ready = 1; tick(); redirect_ready = 0;
        ertn_flush = 1; icacop_flush = 1; idle_flush = 1; refetch_flush = 1; ws_pc = 32'h1C00_0300;
        tick();
        clr_req();
        checks++;
        if (redirect_pc !== 32'h1C00_2000 || ctrl_state !== 2'd1 || flush_cnt !== 16'd2) begin
            errors++;
            $display("FAIL prio_ertn: pc=%h st=%0d cnt=%0d, need 1c002000 1 2",
                     redirect_pc, ctrl_state, flush_cnt);
        end
        redirect_ready = 1; tick(); redirect_ready = 0;
        icacop_flush = 1; idle_flush = 1; refetch_flush = 1;
        tick();
        clr_req();
        checks++;
        if (redirect_pc !== 32'h1C00_0304 || ctrl_state !== 2'd2 || redirect_valid !== 0) begin
            errors++;
            $display("FAIL prio_icacop: pc=%h st=%0d rv=%b, need 1c000304 2 0",
                     redirect_pc, ctrl_state, redirect_valid);
        end
        do_reset();
        idle_flush = 1; refetch_flush = 1;
        tick();
        clr_req();
        checks++;
        if (redirect_pc !== 32'h1C00_0304 || ctrl_state !== 2'd3 || fetch_hold !== 1) begin
            errors++;
            $display("FAIL prio_idle: pc=%h st=%0d fh=%b, need 1c000304 3 1",
                     redirect_pc, ctrl_state, fetch_hold);
        end
    endtask

    task automatic test_icacop();
        do_reset();
        icacop_flush = 1; ws_pc = 32'h1C00_0100;
        tick();
        clr_req();
        checks++;
        if (ctrl_state !== 2'd2 || fetch_hold !== 1 || redirect_valid !== 0 || pipe_flush !== 1) begin
            errors++;
            $display("FAIL cacop_enter: st=%0d fh=%b rv=%b pf=%b, need 2 1 0 1",
                     ctrl_state, fetch_hold, redirect_valid, pipe_flush);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ctrl_state !== 2'd2 || fetch_hold !== 1 || pipe_flush !== 0 || redirect_valid !== 0) begin
                errors++;
                $display("FAIL cacop_wait%0d: st=%0d fh=%b pf=%b rv=%b, need 2 1 0 0",
                         i, ctrl_state, fetch_hold, pipe_flush, redirect_valid);
            end
        end
        icacop_done = 1;
        tick();
        icacop_done = 0;
        checks++;
        if (ctrl_state !== 2'd1 || redirect_valid !== 1 || redirect_pc !== 32'h1C00_0104 || fetch_hold !== 1) begin
            errors++;
            $display("FAIL cacop_redir: st=%0d rv=%b pc=%h fh=%b, need 1 1 1c000104 1",
                     ctrl_state, redirect_valid, redirect_pc, fetch_hold);
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        checks++;
        if (ctrl_state !== 2'd0 || fetch_hold !== 0 || redirect_valid !== 0) begin
            errors++;
            $display("FAIL cacop_return: st=%0d fh=%b rv=%b, need 0 0 0",
                     ctrl_state, fetch_hold, redirect_valid);
        end
        // done arriving together with the request still releases CACOP
        icacop_flush = 1; icacop_done = 1; ws_pc = 32'h1C00_0200;
        tick();
        clr_req();
        checks++;
        if (ctrl_state !== 2'd2) begin
            errors++;
            $display("FAIL cacop_early_enter: st=%0d, need 2", ctrl_state);
        end
        tick();
        checks++;
        if (ctrl_state !== 2'd1 || redirect_pc !== 32'h1C00_0204) begin
            errors++;
            $display("FAIL cacop_early_done: st=%0d pc=%h, need 1 1c000204", ctrl_state, redirect_pc);
        end
    endtask

    task automatic test_idle();
        do_reset();
        idle_flush = 1; ws_pc = 32'hFFFF_FFFC;
        tick();
        clr_req();
        checks++;
        if (ctrl_state !== 2'd3 || redirect_pc !== 32'd0 || fetch_hold !== 1 || pipe_flush !== 1) begin
            errors++;
            $display("FAIL idle_enter: st=%0d pc=%h fh=%b pf=%b, need 3 00000000 1 1",
                     ctrl_state, redirect_pc, fetch_hold, pipe_flush);
        end
        // a new request while idle must be ignored
        refetch_flush = 1; ws_pc = 32'h1C00_0500;
        for (int i = 0; i < 19; i++) begin
            tick();
            refetch_flush = 0;
            checks++;
            if (ctrl_state !== 2'd3 || fetch_hold !== 1 || pipe_flush !== 0 || flush_cnt !== 16'd1) begin
                errors++;
                $display("FAIL idle_hold%0d: st=%0d fh=%b pf=%b cnt=%0d, need 3 1 0 1",
                         i, ctrl_state, fetch_hold, pipe_flush, flush_cnt);
            end
        end
        int_pending = 1;
        tick();
        int_pending = 0;
        checks++;
        if (ctrl_state !== 2'd1 || redirect_valid !== 1 || redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL idle_wake: st=%0d rv=%b pc=%h, need 1 1 00000000",
                     ctrl_state, redirect_valid, redirect_pc);
        end
        redirect_ready = 1; tick(); redirect_ready = 0;
        checks++;
        if (ctrl_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_return: st=%0d, need 0", ctrl_state);
        end
    endtask

    task automatic test_refetch_stall();
        do_reset();
        refetch_flush = 1; ws_pc = 32'h1C00_0200; csr_eentry = 32'h1C00_9000;
        tick();
        clr_req();
        excp_flush = 1;  // arrives during REDIR and must be ignored
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctrl_state !== 2'd1 || redirect_valid !== 1 || redirect_pc !== 32'h1C00_0204 ||
                flush_cnt !== 16'd1 || pipe_flush !== (i == 0)) begin
                errors++;
                $display("FAIL refetch_hold%0d: st=%0d rv=%b pc=%h cnt=%0d pf=%b, need 1 1 1c000204 1 %0d",
                         i, ctrl_state, redirect_valid, redirect_pc, flush_cnt, pipe_flush, (i == 0));
            end
            tick();
            excp_flush = 0;
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        checks++;
        if (ctrl_state !== 2'd0 || redirect_valid !== 0 || flush_cnt !== 16'd1 || pipe_flush !== 0) begin
            errors++;
            $display("FAIL refetch_return: st=%0d rv=%b cnt=%0d pf=%b, need 0 0 1 0",
                     ctrl_state, redirect_valid, flush_cnt, pipe_flush);
        end
    endtask

    task automatic test_reset_cacop();
        do_reset();
        icacop_flush = 1; ws_pc = 32'h1C00_0700;
        tick();
        clr_req();
        tick();
        reset = 1;
        tick();
        checks++;
        if (ctrl_state !== 2'd0 || pipe_flush !== 0 || redirect_valid !== 0 || fetch_hold !== 0 ||
            redirect_pc !== 32'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_in_cacop: st=%0d pf=%b rv=%b fh=%b pc=%h cnt=%0d, need all zero",
                     ctrl_state, pipe_flush, redirect_valid, fetch_hold, redirect_pc, flush_cnt);
        end
        reset = 0;
        icacop_done = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            icacop_done = 0;
            checks++;
            if (pipe_flush !== 0 || redirect_valid !== 0 || ctrl_state !== 2'd0) begin
                errors++;
                $display("FAIL reset_after%0d: pf=%b rv=%b st=%0d, need 0 0 0",
                         i, pipe_flush, redirect_valid, ctrl_state);
            end
        end
    endtask

    initial begin
        reset = 1;
        redirect_ready = 0;
        clr_req();
        test_reset();
        test_quiet();
        test_tlbrefill();
        test_priority();
        test_icacop();
        test_idle();
        test_refetch_stall();
        test_reset_cacop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
